cook_timer_controller: RTL and testbench

- Sequences a microwave cook cycle. Takes the M:SS digits produced by timer_input and counts them down once per second while the magnetron is enabled.
- Handles start, stop and clear buttons, the door interlock, pause/resume and end-of-cycle signalling.
- Gates keypad/switch entry through entry_en, which drives the priority encoder enable.
- Sits between timer_input and the display/magnetron drivers.

---
 rtl/cook_pkg.sv | 28 ++
 rtl/bcd_mmss_down_counter.sv | 46 ++++
 rtl/cook_timer_controller.sv | 141 ++++++++++++++
 tb/tb_cook_timer_controller.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cook_pkg.sv
// rtl/cook_pkg.sv - shared types, BCD limits and clamp helper for the cook timer
// Purpose: state encoding, M:SS digit struct and digit clamping used by the
//          cook timer controller and its BCD down counter.
// Ports:   none (package).
package cook_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COOKING = 2'd1,
    PAUSED  = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] minutes;
    logic [3:0] tens;
    logic [3:0] units;
  } mmss_t;

  localparam logic [3:0] MAX_MIN   = 4'd9;
  localparam logic [3:0] MAX_TENS  = 4'd5;
  localparam logic [3:0] MAX_UNITS = 4'd9;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] d, input logic [3:0] max_d);
    return (d > max_d) ? max_d : d;
  endfunction

endpackage

// File: rtl/bcd_mmss_down_counter.sv
// rtl/bcd_mmss_down_counter.sv - loadable M:SS BCD down counter with borrow chain
// Purpose: holds the displayed M:SS digits, loads new digits or decrements by
//          one second, and flags the decrement that lands on 0:00.
// Ports:   clk, rst        - clock, asynchronous active-high reset
//          load            - load load_digits this cycle (wins over dec)
//          load_digits     - digits to load
//          dec             - decrement by one second
//          digits          - current M:SS value
//          zero            - this cycle's decrement takes 0:01 to 0:00
module bcd_mmss_down_counter
  import cook_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  mmss_t load_digits,
  input  logic  dec,
  output mmss_t digits,
  output logic  zero
);

  // Flag the transition rather than the level so the caller can change
  // state on the same edge that the display reaches 0:00.
  assign zero = dec && !load && (digits == mmss_t'({4'd0, 4'd0, 4'd1}));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits <= '0;
    end else if (load) begin
      digits <= load_digits;
    end else if (dec && digits != '0) begin
      if (digits.units != 4'd0) begin
        digits.units <= digits.units - 4'd1;
      end else begin
        digits.units <= MAX_UNITS;
        if (digits.tens != 4'd0) begin
          digits.tens <= digits.tens - 4'd1;
        end else begin
          digits.tens    <= MAX_TENS;
          digits.minutes <= digits.minutes - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/cook_timer_controller.sv
// rtl/cook_timer_controller.sv - microwave cook cycle sequencer and M:SS countdown
// Purpose: button edge detection, IDLE/COOKING/PAUSED/DONE sequencing, the
//          one-second prescaler, the done-hold timer and the door interlock.
// Ports:   clk, rst                        - clock, asynchronous active-high reset
//          start, stop, clear              - button levels (edge detected here)
//          door_closed                     - door interlock, 1 = closed
//          set_minutes/tens/units          - BCD time from the entry block
//          disp_minutes/tens/units         - BCD time shown
//          mag_on, done, entry_en, state_o - magnetron, beeper, entry enable, state
module cook_timer_controller
  import cook_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100,
  parameter int DONE_CYCLES   = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       door_closed,
  input  logic [3:0] set_minutes,
  input  logic [3:0] set_tens,
  input  logic [3:0] set_units,
  output logic [3:0] disp_minutes,
  output logic [3:0] disp_tens,
  output logic [3:0] disp_units,
  output logic       mag_on,
  output logic       done,
  output logic       entry_en,
  output logic [1:0] state_o
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int DW = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;

  state_t          state;
  logic [PW-1:0]   presc;
  logic [DW-1:0]   done_cnt;
  logic            start_q, stop_q, clear_q;
  logic            start_e, stop_e, clear_e;
  logic            tick, start_go;
  logic            cnt_load, cnt_dec, cnt_zero;
  mmss_t           set_raw, set_clamped, cnt_load_digits, disp;

  assign start_e = start & ~start_q;
  assign stop_e  = stop  & ~stop_q;
  assign clear_e = clear & ~clear_q;

  assign set_raw     = {set_minutes, set_tens, set_units};
  assign set_clamped = {bcd_clamp(set_minutes, MAX_MIN),
                        bcd_clamp(set_tens, MAX_TENS),
                        bcd_clamp(set_units, MAX_UNITS)};

  assign tick = (state == COOKING) && (presc == PW'(TICKS_PER_SEC - 1));

  // Clear and stop outrank start; a closed door and a non-zero time are required.
  assign start_go = start_e && !clear_e && !stop_e && door_closed && (set_clamped != '0);

  always_comb begin
    cnt_load        = 1'b0;
    cnt_load_digits = set_raw;
    cnt_dec         = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_load = 1'b1;
        if (start_go) cnt_load_digits = set_clamped;
      end
      COOKING: cnt_dec = tick && !clear_e;
      default: ;
    endcase
  end

  bcd_mmss_down_counter u_counter (
    .clk         (clk),
    .rst         (rst),
    .load        (cnt_load),
    .load_digits (cnt_load_digits),
    .dec         (cnt_dec),
    .digits      (disp),
    .zero        (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      presc    <= '0;
      done_cnt <= '0;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
      clear_q  <= 1'b0;
    end else begin
      start_q <= start;
      stop_q  <= stop;
      clear_q <= clear;
      unique case (state)
        IDLE: begin
          presc    <= '0;
          done_cnt <= '0;
          if (start_go) state <= COOKING;
        end
        COOKING: begin
          if (clear_e) begin
            state <= IDLE;
            presc <= '0;
          end else begin
            // A tick consumes the second even when pausing on the same cycle,
            // so resume never repeats it; otherwise a pause freezes the phase.
            if (tick) presc <= '0;
            else if (!stop_e && door_closed) presc <= presc + PW'(1);
            if (cnt_zero) state <= DONE;
            else if (stop_e || !door_closed) state <= PAUSED;
          end
        end
        PAUSED: begin
          if (clear_e || stop_e) state <= IDLE;
          else if (start_e && door_closed) state <= COOKING;
        end
        DONE: begin
          if (clear_e || stop_e || done_cnt == DW'(DONE_CYCLES - 1)) begin
            state    <= IDLE;
            done_cnt <= '0;
          end else begin
            done_cnt <= done_cnt + DW'(1);
          end
        end
      endcase
    end
  end

  // Outputs decode the state register; the door term keeps the interlock
  // free of any clock latency.
  assign mag_on       = (state == COOKING) & door_closed;
  assign entry_en     = (state == IDLE);
  assign done         = (state == DONE);
  assign state_o      = state;
  assign disp_minutes = disp.minutes;
  assign disp_tens    = disp.tens;
  assign disp_units   = disp.units;

endmodule

// File: tb/tb_cook_timer_controller.sv
// tb/tb_cook_timer_controller.sv - self-checking bench for cook_timer_controller
module tb_cook_timer_controller;

  localparam int TPS = 4;
  localparam int DC  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, stop = 1'b0, clear = 1'b0, door_closed = 1'b1;
  logic [3:0] set_minutes = 4'd0, set_tens = 4'd0, set_units = 4'd0;
  logic [3:0] disp_minutes, disp_tens, disp_units;
  logic       mag_on, done, entry_en;
  logic [1:0] state_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  cook_timer_controller #(.TICKS_PER_SEC(TPS), .DONE_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .door_closed(door_closed), .set_minutes(set_minutes), .set_tens(set_tens),
    .set_units(set_units), .disp_minutes(disp_minutes), .disp_tens(disp_tens),
    .disp_units(disp_units), .mag_on(mag_on), .done(done), .entry_en(entry_en),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Reference model: remaining time kept as plain seconds, phase as an int.
  int          m_st, m_secs, m_phase, m_dcnt;
  logic [11:0] m_disp;
  logic        p_start, p_stop, p_clear;

  function automatic int clamp_secs();
    int mm, tt, uu;
    mm = (set_minutes > 9) ? 9 : int'(set_minutes);
    tt = (set_tens > 5) ? 5 : int'(set_tens);
    uu = (set_units > 9) ? 9 : int'(set_units);
    return mm * 60 + tt * 10 + uu;
  endfunction

  function automatic logic [11:0] to_disp(input int s);
    return {4'(s / 60), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  task automatic m_reset();
    m_st = 0; m_secs = 0; m_phase = 0; m_dcnt = 0; m_disp = '0;
    p_start = 1'b0; p_stop = 1'b0; p_clear = 1'b0;
  endtask

  task automatic m_step();
    logic se, pe, ce, tk;
    se = start & ~p_start; pe = stop & ~p_stop; ce = clear & ~p_clear;
    p_start = start; p_stop = stop; p_clear = clear;
    case (m_st)
      0: begin
        if (se && !ce && !pe && door_closed && clamp_secs() > 0) begin
          m_secs = clamp_secs(); m_phase = 0; m_st = 1; m_disp = to_disp(m_secs);
        end else begin
          m_disp = {set_minutes, set_tens, set_units};
        end
      end
      1: begin
        if (ce) m_st = 0;
        else begin
          tk = (m_phase == TPS - 1);
          if (tk) begin
            m_phase = 0; m_secs = m_secs - 1; m_disp = to_disp(m_secs);
          end else if (!pe && door_closed) m_phase = m_phase + 1;
          if (tk && m_secs == 0) begin m_st = 3; m_dcnt = 0; end
          else if (pe || !door_closed) m_st = 2;
        end
      end
      2: begin
        if (ce || pe) m_st = 0;
        else if (se && door_closed) m_st = 1;
      end
      default: begin
        if (ce || pe || m_dcnt == DC - 1) m_st = 0;
        else m_dcnt = m_dcnt + 1;
      end
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%h expected=%h t=%0t", name, got, exp, $time);
  endtask

  task automatic tick(input string name);
    m_step();
    @(posedge clk); #1;
    chk(name, {15'd0, state_o, disp_minutes, disp_tens, disp_units, mag_on, done, entry_en},
        {15'd0, 2'(m_st), m_disp, (m_st == 1) && door_closed, m_st == 3, m_st == 0});
  endtask

  task automatic run(input int n, input string name);
    for (int i = 0; i < n; i++) tick(name);
  endtask

  task automatic press_start();
    start = 1'b1; tick("start_edge"); start = 1'b0;
  endtask

  task automatic set_time(input logic [3:0] m, input logic [3:0] t, input logic [3:0] u);
    set_minutes = m; set_tens = t; set_units = u;
  endtask

  task automatic do_reset();
    rst = 1'b1; m_reset();
    #2;
    chk("reset_outputs", {state_o, disp_minutes, disp_tens, disp_units, mag_on, done, entry_en},
        {2'd0, 12'h000, 1'b0, 1'b0, 1'b1});
    rst = 1'b0;
  endtask

  function automatic logic [11:0] disp_now();
    return {disp_minutes, disp_tens, disp_units};
  endfunction

  typedef struct {
    logic [3:0]  m, t, u;
    logic        door;
    logic [1:0]  st;
    logic [11:0] disp;
  } vec_t;

  vec_t vt[7];

  initial begin
    vt[0] = '{4'd0,  4'd1, 4'd2,  1'b1, 2'd1, 12'h012};
    vt[1] = '{4'd0,  4'd0, 4'd0,  1'b1, 2'd0, 12'h000};
    vt[2] = '{4'd0,  4'd0, 4'd5,  1'b0, 2'd0, 12'h005};
    vt[3] = '{4'd0,  4'd7, 4'd12, 1'b1, 2'd1, 12'h059};
    vt[4] = '{4'd12, 4'd3, 4'd0,  1'b1, 2'd1, 12'h930};
    vt[5] = '{4'd0,  4'd0, 4'd15, 1'b1, 2'd1, 12'h009};
    vt[6] = '{4'd0,  4'd6, 4'd0,  1'b1, 2'd1, 12'h050};

    #3; do_reset();

    // Table: IDLE follows raw set_*, then start latches clamped or is ignored.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      set_time(vt[i].m, vt[i].t, vt[i].u); door_closed = vt[i].door;
      tick("idle_follow");
      chk("idle_raw_disp", 32'(disp_now()), 32'({vt[i].m, vt[i].t, vt[i].u}));
      press_start();
      chk("start_state", 32'(state_o), 32'(vt[i].st));
      chk("start_disp", 32'(disp_now()), 32'(vt[i].disp));
      chk("start_mag", 32'(mag_on), 32'(vt[i].st == 2'd1));
      door_closed = 1'b1;
    end

    // 0:12 full cycle through DONE and back to IDLE.
    do_reset(); set_time(0, 1, 2); tick("s1_idle"); press_start();
    run(3, "s1_run"); chk("s1_pre_tick", 32'(disp_now()), 32'h012);
    run(1, "s1_run"); chk("s1_first_tick", 32'(disp_now()), 32'h011);
    run(8, "s1_run"); chk("s1_0_09", 32'(disp_now()), 32'h009);
    run(35, "s1_run"); chk("s1_0_01", {state_o, disp_now()}, {2'd1, 12'h001});
    run(1, "s1_run"); chk("s1_done", {state_o, done, disp_now()}, {2'd3, 1'b1, 12'h000});
    run(7, "s1_hold"); chk("s1_done_hold", 32'(done), 32'd1);
    run(1, "s1_exit"); chk("s1_idle_back", {state_o, entry_en}, {2'd0, 1'b1});

    // 1:00 double borrow.
    do_reset(); set_time(1, 0, 0); tick("s2_idle"); press_start();
    run(4, "s2_run"); chk("s2_double_borrow", 32'(disp_now()), 32'h059);

    // Door opens mid-prescale; resume uses only the remaining phase.
    do_reset(); set_time(0, 3, 0); tick("s3_idle"); press_start();
    run(2, "s3_run");
    door_closed = 1'b0; #1;
    chk("s3_interlock", 32'(mag_on), 32'd0);
    run(5, "s3_paused"); chk("s3_frozen", {state_o, disp_now()}, {2'd2, 12'h030});
    door_closed = 1'b1; run(2, "s3_closed"); chk("s3_still_paused", 32'(state_o), 32'd2);
    press_start(); run(1, "s3_resume"); chk("s3_resume_hold", 32'(disp_now()), 32'h030);
    run(1, "s3_resume"); chk("s3_resume_tick", 32'(disp_now()), 32'h029);

    // Stop on the final tick: DONE wins.
    do_reset(); set_time(0, 0, 2); tick("s5_idle"); press_start();
    run(7, "s5_run"); chk("s5_at_one", 32'(disp_now()), 32'h001);
    stop = 1'b1; tick("s5_stop_tick"); stop = 1'b0;
    chk("s5_done_over_pause", {state_o, disp_now()}, {2'd3, 12'h000});

    // Clear from PAUSED, display follows set_* one cycle later.
    do_reset(); set_time(0, 3, 0); tick("s5b_idle"); press_start(); run(1, "s5b_run");
    stop = 1'b1; tick("s5b_stop"); stop = 1'b0;
    chk("s5b_paused", 32'(state_o), 32'd2);
    set_time(1, 2, 3); clear = 1'b1; tick("s5b_clear"); clear = 1'b0;
    chk("s5b_idle_hold", {state_o, disp_now()}, {2'd0, 12'h030});
    tick("s5b_follow"); chk("s5b_follow", 32'(disp_now()), 32'h123);

    // Reset while cooking at 0:45.
    do_reset(); set_time(0, 4, 5); tick("s6_idle"); press_start(); run(2, "s6_run");
    chk("s6_cooking", {state_o, mag_on}, {2'd1, 1'b1});
    do_reset();
    tick("s6_after"); chk("s6_follow", {state_o, disp_now()}, {2'd0, 12'h045});

    // Randomized stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(9) == 0) start = ~start;
      if ($urandom_range(29) == 0) stop = ~stop;
      if ($urandom_range(59) == 0) clear = ~clear;
      if ($urandom_range(59) == 0) door_closed = ~door_closed;
      if ($urandom_range(24) == 0)
        set_time(($urandom_range(7) == 0) ? 4'($urandom_range(15)) : 4'd0,
                 4'($urandom_range(2)), 4'($urandom_range(15)));
      if ($urandom_range(999) == 0) do_reset();
      tick("rand_model");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
